// File: rtl/vedic_seq_mult.sv
// Sequential Urdhva-Tiryakbhyam multiplier: one 4x4 digit product per clock,
// shifted and accumulated into a 2*WIDTH-bit sum; valid/ready on both sides.
// Optional build macro VEDIC_SIGNED_EN: operands are two's complement; the
// digit loop runs on magnitudes and the final sum is negated when the signs differ.
module vedic_seq_mult #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
);

   localparam int K  = WIDTH / 4;
   localparam int PW = 2 * WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

   logic [1:0]       state_q, state_d;
   logic             alive_q;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    p_q, p_d;
   logic             ov_q, ov_d;
   logic [CNT_W-1:0] i_q, i_d, j_q, j_d;

   logic [3:0]       a_dig, b_dig;
   logic [7:0]       pp;
   logic [PW-1:0]    term, sum, p_fin;
   logic [WIDTH-1:0] a_in, b_in;
   logic             last;

`ifdef VEDIC_SIGNED_EN
   logic sign_q, sign_d;
   // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
   assign a_in  = a[WIDTH-1] ? -a : a;
   assign b_in  = b[WIDTH-1] ? -b : b;
   assign p_fin = sign_q ? -sum : sum;
`else
   assign a_in  = a;
   assign b_in  = b;
   assign p_fin = sum;
`endif

   // ready only once out of reset for at least one edge and idle
   assign in_ready  = alive_q && (state_q == S_IDLE);
   assign out_valid = ov_q;
   assign p         = p_q;

   // current digit pair, its product and its weighted position
   always_comb begin
      a_dig = 4'(a_q >> (4 * i_q));
      b_dig = 4'(b_q >> (4 * j_q));
      pp    = a_dig * b_dig;
      term  = PW'(pp) << (4 * (i_q + j_q));
      sum   = acc_q + term;
      last  = (i_q == LAST) && (j_q == LAST);
   end

   // next-state: accept, iterate digits j-fastest, hold result until taken
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      p_d     = p_q;
      ov_d    = ov_q;
      i_d     = i_q;
      j_d     = j_q;
`ifdef VEDIC_SIGNED_EN
      sign_d  = sign_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid && alive_q) begin
               a_d     = a_in;
               b_d     = b_in;
`ifdef VEDIC_SIGNED_EN
               sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
`endif
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            acc_d = sum;
            if (j_q == LAST) begin
               j_d = '0;
               i_d = i_q + 1'b1;
            end else begin
               j_d = j_q + 1'b1;
            end
            if (last) begin
               p_d     = p_fin;
               ov_d    = 1'b1;
               i_d     = '0;
               j_d     = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state registers; reset discards any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         alive_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         ov_q    <= 1'b0;
         i_q     <= '0;
         j_q     <= '0;
`ifdef VEDIC_SIGNED_EN
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
         ov_q    <= ov_d;
         i_q     <= i_d;
         j_q     <= j_d;
`ifdef VEDIC_SIGNED_EN
         sign_q  <= sign_d;
`endif
      end
   end

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Scoreboard bench for vedic_seq_mult: WIDTH=8 instance for handshake, stall,
// reset and value checks; WIDTH=16 instance for the long-latency case.
module tb_vedic_seq_mult;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [7:0]  a = '0, b = '0;
   logic [15:0] p;

   logic        iv16 = 1'b0, ir16, ov16;
   logic [15:0] a16 = '0, b16 = '0;
   logic [31:0] p16;

   typedef struct {
      logic [15:0] p;
      int          acc;
   } sb_t;
   sb_t sb[$];

   int checks = 0, fails = 0, cyc = 0;
   bit busy = 1'b0, alive = 1'b0, prev_v = 1'b0;

   vedic_seq_mult #(.WIDTH(8), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p)
   );

   vedic_seq_mult #(.WIDTH(16), .CNT_W(8)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .out_valid(ov16), .out_ready(1'b1), .p(p16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
`ifdef VEDIC_SIGNED_EN
      logic signed [15:0] sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      return 16'(sx * sy);
`else
      return 16'(x) * 16'(y);
`endif
   endfunction

   function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y);
`ifdef VEDIC_SIGNED_EN
      logic signed [31:0] sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      return 32'(sx * sy);
`else
      return 32'(x) * 32'(y);
`endif
   endfunction

   // output side: latency on rise, value every valid cycle, pop on transfer
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_v = 1'b0;
      end else begin
         if (alive) chk("in_ready", in_ready, !busy);
         if (out_valid && !prev_v) begin
            if (sb.size() == 0) chk("spurious_valid", out_valid, 1'b0);
            else                chk("latency", cyc - sb[0].acc, 4);
         end
         if (out_valid && sb.size() != 0) begin
            chk("p", p, sb[0].p);
            if (out_ready) begin
               void'(sb.pop_front());
               busy = 1'b0;
            end
         end
         prev_v = out_valid;
      end
   end

   task automatic send(input logic [7:0] x, input logic [7:0] y);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("send_wait", in_ready, 1'b1);
         return;
      end
      in_valid = 1'b1; a = x; b = y;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back('{model8(x, y), cyc});
      busy = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1'b0);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_p"}, p, 16'h0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 chk_reset_vals("rst");
      chk("rst_ir16", ir16, 1'b0);
      rst_n = 1'b1;
      #1 chk("ir_at_release", in_ready, 1'b0);
      @(posedge clk); #1;
      alive = 1'b1;
      chk("ir_after_rst", in_ready, 1'b1);

      // full-scale operands and back-to-back pairs
      send(8'hFF, 8'hFF);
      wait_idle();
      send(8'h00, 8'hA5);
      send(8'h0C, 8'h0D);
      wait_idle();

      // backpressure with in_valid noise while the result is held
      out_ready = 1'b0;
      send(8'h12, 8'h34);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("stall_rise", out_valid, 1'b1);
      repeat (10) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1'b1);
         @(posedge clk); #1;
         in_valid = ~in_valid; a = 8'h55; b = 8'hAA;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // reset in the middle of CALC
      send(8'hFF, 8'hFF);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb.delete();
      busy = 1'b0;
      alive = 1'b0;
      #1 chk_reset_vals("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      alive = 1'b1;
      repeat (8) @(posedge clk);
      #1 chk("post_rst_quiet", out_valid, 1'b0);
      send(8'h03, 8'h05);
      wait_idle();

      // sign-boundary operands
      send(8'h80, 8'h7F);
      send(8'h80, 8'h80);
      send(8'hFF, 8'h01);
      wait_idle();

      for (int k = 0; k < 6; k++) send(8'($urandom), 8'($urandom));
      wait_idle();

      // 16-bit instance: 16-cycle latency
      chk("ir16", ir16, 1'b1);
      iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF;
      @(posedge clk); #1;
      iv16 = 1'b0;
      n = 0;
      while (!ov16 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("lat16", n, 16);
      chk("p16", p16, model16(16'hFFFF, 16'hFFFF));
      repeat (3) @(posedge clk);
      #1 chk("ir16_back", ir16, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
